regfile_wb_arbiter: RTL and testbench
=====================================

# regfile_wb_arbiter

Shares the single write port of the CPU register file between two writeback sources. Source A is the ALU/single-cycle path and has priority. Source B is the long-latency path: loads and mult/div results. The block arbitrates with a starvation guard and registers the winning write onto the register-file port. It also keeps a per-register scoreboard of outstanding source-B writes, so decode can stall on RAW hazards.

## Interface
Parameters:
- STARVE_LIMIT, default 3: number of consecutive cycles B may be refused before it is forced to win; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- a_valid  in  1  source A has a write.
- a_ready  out  1  source A write accepted this cycle.
- a_addr  in  5  source A destination register.
- a_data  in  32  source A value.
- b_valid  in  1  source B has a write.
- b_ready  out  1  source B write accepted this cycle.
- b_addr  in  5  source B destination register.
- b_data  in  32  source B value.
- rsv_valid  in  1  a long-latency op is issuing; reserve its destination register.
- rsv_addr  in  5  register to reserve.
- busy  out  32  scoreboard; bit n=1 means a B write to register n is outstanding. Bit 0 is always 0.
- wr_en  out  1  register-file write enable (registered).
- wr_addr  out  5  register-file write address (registered).
- wr_data  out  32  register-file write data (registered).
- err  out  1  sticky protocol-error flag.

## Operation
- Grant logic is combinational from a_valid, b_valid and the starvation counter (starve).
  - If b_valid and starve==STARVE_LIMIT: grant B.
  - Else if a_valid: grant A.
  - Else if b_valid: grant B.
  - At most one grant per cycle.
- a_ready and b_ready equal their grant; a transfer is valid & ready. Ready never depends on the requester's own addr/data.
- Writes to register 0:
  - The transfer is consumed normally.
  - wr_en stays 0 next cycle.
  - A B write to register 0 never touches the scoreboard.
- Starvation counter: 4-bit, saturates at STARVE_LIMIT.
  - Increments when b_valid & !b_ready.
  - Clears on a B transfer or when b_valid=0.
- Scoreboard:
  - Set: rsv_valid with rsv_addr!=0 sets busy[rsv_addr].
  - Clear: a B transfer with b_addr!=0 clears busy[b_addr]. Both take effect at the clock edge.
  - Same-cycle set and clear of the same register: set wins, because the new reservation supersedes the old one.
  - A writes never change busy.
- err (sticky until reset) is set by either of:
  - rsv_valid to a register that is already busy and not cleared in that same cycle;
  - a B transfer to a nonzero register whose busy bit is 0.

## Timing
- Arbitration has zero added latency: ready is asserted in the same cycle as valid when the source wins.
- Transfer in cycle N drives wr_en/wr_addr/wr_data in cycle N+1. The register file commits at the end of N+1.
- The busy bit is cleared from cycle N+1, the same cycle the value appears on the write port. Decode must treat busy=0 as "value is in flight to the register file" and relies on the register file's write-before-read bypass.
- wr_en is a one-cycle pulse per transfer. Back-to-back transfers produce back-to-back pulses.
- B throughput under continuous A traffic: at least 1 write per STARVE_LIMIT+1 cycles.
- Reset values: wr_en=0, wr_addr=0, wr_data=0, busy=0, err=0, starve=0. a_ready/b_ready are 0 while reset is asserted.
- Reset mid-operation:
  - Pending reservations and any registered write are discarded; no wr_en pulse follows reset release.
  - The first cycle after release arbitrates normally.

## Structure
- Shared package mips_wb_pkg holds:
  - REG_ADDR_W=5 and DATA_W=32;
  - typedef wb_req_t {addr, data};
  - the constant REG_ZERO=5'd0.
- Sub-module wb_scoreboard holds the 32-bit busy vector, set/clear priority and error detection. The arbiter, starvation counter and output register live in the top module.

## Test plan
- A only, addr=5, data=32'hDEADBEEF → a_ready same cycle; next cycle wr_en=1, wr_addr=5, wr_data=32'hDEADBEEF.
- A and B valid continuously, STARVE_LIMIT=3 → grant pattern A,A,A,B repeating; b_ready asserted every 4th cycle; wr_en high every cycle.
- Reserve reg 8, then B write to reg 8 three cycles later → busy[8]=1 from the cycle after rsv; busy[8]=0 and wr_addr=8 in the cycle after the B transfer; err stays 0.
- Same cycle: rsv_addr=8 and B transfer to 8 with busy[8]=1 → busy[8] remains 1 and err stays 0. Separately, B write to reg 9 with busy[9]=0 → err=1, held through later traffic until reset.
- A write to reg 0 with data 32'h1234 → a_ready=1, wr_en stays 0. rsv_addr=0 → busy stays 0.
- Assert reset in the cycle after a B transfer (wr_en about to pulse) with busy[3]=1 → wr_en=0, busy=0 and err=0 immediately (asynchronous), and no write issued after release.

Source files
------------

// File: rtl/mips_wb_pkg.sv
// Shared writeback types and constants for the register-file write-port arbiter.
package mips_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register scoreboard of outstanding long-latency writes with sticky protocol-error detection.
module wb_scoreboard
  import mips_wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rsv_valid,
  input  logic [REG_ADDR_W-1:0] rsv_addr,
  input  logic                  clr_valid,
  input  logic [REG_ADDR_W-1:0] clr_addr,
  output logic [31:0]           busy,
  output logic                  err
);

  logic        set_hit;
  logic        clr_hit;
  logic [31:0] busy_nxt;
  logic        err_nxt;

  always_comb begin
    set_hit  = rsv_valid && (rsv_addr != REG_ZERO);
    clr_hit  = clr_valid && (clr_addr != REG_ZERO);
    busy_nxt = busy;
    // Set is applied after clear: a fresh reservation supersedes the retiring one.
    if (clr_hit) busy_nxt[clr_addr] = 1'b0;
    if (set_hit) busy_nxt[rsv_addr] = 1'b1;
    err_nxt = err
            | (set_hit && busy[rsv_addr] && !(clr_hit && (clr_addr == rsv_addr)))
            | (clr_hit && !busy[clr_addr]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= busy_nxt;
      err  <= err_nxt;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between source A (priority) and source B
// (starvation-guarded), registers the winning write and tracks outstanding B writes.
module regfile_wb_arbiter
  import mips_wb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic [REG_ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0]     a_data,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic [REG_ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0]     b_data,
  input  logic                  rsv_valid,
  input  logic [REG_ADDR_W-1:0] rsv_addr,
  output logic [31:0]           busy,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic                  err
);

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0] starve;
  logic       grant_a;
  logic       grant_b;
  logic       a_xfer;
  logic       b_xfer;
  wb_req_t    win;

  // Ready is held low while reset is asserted, independent of the clock.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      if (b_valid && (starve == STARVE_MAX)) grant_b = 1'b1;
      else if (a_valid)                      grant_a = 1'b1;
      else if (b_valid)                      grant_b = 1'b1;
    end
  end

  assign a_ready = grant_a;
  assign b_ready = grant_b;
  assign a_xfer  = a_valid && grant_a;
  assign b_xfer  = b_valid && grant_b;

  always_comb begin
    win = '{addr: a_addr, data: a_data};
    if (grant_b) win = '{addr: b_addr, data: b_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve <= '0;
    end else if (!b_valid || b_xfer) begin
      starve <= '0;
    end else if (starve != STARVE_MAX) begin
      starve <= starve + 4'd1;
    end
  end

  // Writes to register 0 are consumed but never reach the register file.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= (a_xfer || b_xfer) && (win.addr != REG_ZERO);
      if (a_xfer || b_xfer) begin
        wr_addr <= win.addr;
        wr_data <= win.data;
      end
    end
  end

  wb_scoreboard u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .clr_valid (b_xfer),
    .clr_addr  (b_addr),
    .busy      (busy),
    .err       (err)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed table-driven bench for regfile_wb_arbiter with hand-written reset corner case.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        a_valid, b_valid, rsv_valid;
  logic        a_ready, b_ready;
  logic [4:0]  a_addr, b_addr, rsv_addr;
  logic [31:0] a_data, b_data;
  logic [31:0] busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wb_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .a_valid   (a_valid),
    .a_ready   (a_ready),
    .a_addr    (a_addr),
    .a_data    (a_data),
    .b_valid   (b_valid),
    .b_ready   (b_ready),
    .b_addr    (b_addr),
    .b_data    (b_data),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .busy      (busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  aa;
    logic [31:0] ad;
    logic        bv;
    logic [4:0]  ba;
    logic [31:0] bd;
    logic        rv;
    logic [4:0]  ra;
    logic        e_ar;
    logic        e_br;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic [31:0] e_busy;
    logic        e_err;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic vec_t mk(
    input logic av, input logic [4:0] aa, input logic [31:0] ad,
    input logic bv, input logic [4:0] ba, input logic [31:0] bd,
    input logic rv, input logic [4:0] ra,
    input logic e_ar, input logic e_br, input logic e_we,
    input logic [4:0] e_wa, input logic [31:0] e_wd,
    input logic [31:0] e_busy, input logic e_err);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad;
    v.bv = bv; v.ba = ba; v.bd = bd;
    v.rv = rv; v.ra = ra;
    v.e_ar = e_ar; v.e_br = e_br; v.e_we = e_we;
    v.e_wa = e_wa; v.e_wd = e_wd; v.e_busy = e_busy; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    a_valid = 0; a_addr = 0; a_data = 0;
    b_valid = 0; b_addr = 0; b_data = 0;
    rsv_valid = 0; rsv_addr = 0;
  endtask

  initial begin
    //                 av aa  ad             bv ba  bd            rv ra   ar br we wa  wd             busy         err
    vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,           0, 0,  1, 0, 1, 5, 32'hDEADBEEF, 32'h0,      0);
    vecs[1]  = mk(0, 0, 0,            0, 0, 0,           0, 0,  0, 0, 0, 0, 0,            32'h0,      0);
    vecs[2]  = mk(0, 0, 0,            0, 0, 0,           1, 2,  0, 0, 0, 0, 0,            32'h4,      0);
    // A and B both continuous: grants A,A,A,B twice
    vecs[3]  = mk(1, 1, 32'h11,       1, 2, 32'h22,      0, 0,  1, 0, 1, 1, 32'h11,       32'h4,      0);
    vecs[4]  = mk(1, 3, 32'h33,       1, 2, 32'h22,      0, 0,  1, 0, 1, 3, 32'h33,       32'h4,      0);
    vecs[5]  = mk(1, 4, 32'h44,       1, 2, 32'h22,      0, 0,  1, 0, 1, 4, 32'h44,       32'h4,      0);
    vecs[6]  = mk(1, 5, 32'h55,       1, 2, 32'h22,      0, 0,  0, 1, 1, 2, 32'h22,       32'h0,      0);
    vecs[7]  = mk(1, 6, 32'h66,       1, 2, 32'h222,     1, 2,  1, 0, 1, 6, 32'h66,       32'h4,      0);
    vecs[8]  = mk(1, 7, 32'h77,       1, 2, 32'h222,     0, 0,  1, 0, 1, 7, 32'h77,       32'h4,      0);
    vecs[9]  = mk(1, 8, 32'h88,       1, 2, 32'h222,     0, 0,  1, 0, 1, 8, 32'h88,       32'h4,      0);
    vecs[10] = mk(1, 9, 32'h99,       1, 2, 32'h222,     0, 0,  0, 1, 1, 2, 32'h222,      32'h0,      0);
    // register 0 writes and reservations
    vecs[11] = mk(1, 0, 32'h1234,     0, 0, 0,           1, 0,  1, 0, 0, 0, 0,            32'h0,      0);
    vecs[12] = mk(0, 0, 0,            1, 0, 32'h5678,    0, 0,  0, 1, 0, 0, 0,            32'h0,      0);
    // reserve 8, B write to 8 three cycles later
    vecs[13] = mk(0, 0, 0,            0, 0, 0,           1, 8,  0, 0, 0, 0, 0,            32'h100,    0);
    vecs[14] = mk(0, 0, 0,            0, 0, 0,           0, 0,  0, 0, 0, 0, 0,            32'h100,    0);
    vecs[15] = mk(0, 0, 0,            0, 0, 0,           0, 0,  0, 0, 0, 0, 0,            32'h100,    0);
    vecs[16] = mk(0, 0, 0,            1, 8, 32'h88888888,0, 0,  0, 1, 1, 8, 32'h88888888, 32'h0,      0);
    // same-cycle set and clear of reg 8: set wins, no error
    vecs[17] = mk(0, 0, 0,            0, 0, 0,           1, 8,  0, 0, 0, 0, 0,            32'h100,    0);
    vecs[18] = mk(0, 0, 0,            1, 8, 32'hA8,      1, 8,  0, 1, 1, 8, 32'hA8,       32'h100,    0);
    // B write to unreserved reg 9: sticky error
    vecs[19] = mk(0, 0, 0,            1, 9, 32'hB9,      0, 0,  0, 1, 1, 9, 32'hB9,       32'h100,    1);
    vecs[20] = mk(1, 10, 32'hAA,      0, 0, 0,           0, 0,  1, 0, 1, 10, 32'hAA,      32'h100,    1);

    drive_idle();
    reset = 1'b1;
    a_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en",   32'(wr_en),   32'h0);
    check("rst_wr_addr", 32'(wr_addr), 32'h0);
    check("rst_wr_data", wr_data,      32'h0);
    check("rst_busy",    busy,         32'h0);
    check("rst_err",     32'(err),     32'h0);
    check("rst_a_ready", 32'(a_ready), 32'h0);
    drive_idle();
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      a_valid = vecs[i].av; a_addr = vecs[i].aa; a_data = vecs[i].ad;
      b_valid = vecs[i].bv; b_addr = vecs[i].ba; b_data = vecs[i].bd;
      rsv_valid = vecs[i].rv; rsv_addr = vecs[i].ra;
      #1;
      check($sformatf("v%0d_a_ready", i), 32'(a_ready), 32'(vecs[i].e_ar));
      check($sformatf("v%0d_b_ready", i), 32'(b_ready), 32'(vecs[i].e_br));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_wr_en", i), 32'(wr_en), 32'(vecs[i].e_we));
      if (vecs[i].e_we) begin
        check($sformatf("v%0d_wr_addr", i), 32'(wr_addr), 32'(vecs[i].e_wa));
        check($sformatf("v%0d_wr_data", i), wr_data, vecs[i].e_wd);
      end
      check($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
      check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].e_err));
    end

    // Reset lands while a B write is on the port and reg 3 is reserved.
    @(negedge clk);
    drive_idle();
    rsv_valid = 1; rsv_addr = 3;
    @(negedge clk);
    drive_idle();
    b_valid = 1; b_addr = 8; b_data = 32'hABCD;
    #1;
    check("pre_b_ready", 32'(b_ready), 32'h1);
    @(posedge clk);
    #1;
    check("pre_wr_en", 32'(wr_en), 32'h1);
    check("pre_busy",  busy,       32'h8);
    #2;
    reset = 1'b1;
    a_valid = 1'b1; a_addr = 4; b_valid = 1'b1;
    #1;
    check("async_wr_en",   32'(wr_en),   32'h0);
    check("async_busy",    busy,         32'h0);
    check("async_err",     32'(err),     32'h0);
    check("async_a_ready", 32'(a_ready), 32'h0);
    check("async_b_ready", 32'(b_ready), 32'h0);
    @(negedge clk);
    drive_idle();
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_rst_wr_en%0d", k), 32'(wr_en), 32'h0);
      check($sformatf("post_rst_busy%0d", k),  busy,       32'h0);
    end
    @(negedge clk);
    a_valid = 1; a_addr = 12; a_data = 32'hC0C0;
    b_valid = 1; b_addr = 8; b_data = 32'h1;
    #1;
    check("after_a_ready", 32'(a_ready), 32'h1);
    check("after_b_ready", 32'(b_ready), 32'h0);
    @(posedge clk);
    #1;
    check("after_wr_en",   32'(wr_en),   32'h1);
    check("after_wr_addr", 32'(wr_addr), 32'd12);
    check("after_wr_data", wr_data,      32'hC0C0);
    @(negedge clk);
    drive_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
